// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache and D-cache block fills,
// generates the per-word read addresses of a fill and passes D-cache write-through stores.
module mem_arbiter #(
    parameter int unsigned CHUNKS      = 8,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fill_req,
    input  logic [15:0] i_fill_addr,
    input  logic        d_fill_req,
    input  logic [15:0] d_fill_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_out,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic [15:0] fill_data,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        d_wr_ack
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = $clog2(CHUNKS + 1);

    // Clearing the intra-block offset keeps the word stride from carrying into tag bits.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((2 ** OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_FILL = 2'd1,
        D_FILL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;

    // State and fill bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // Next-state and memory/cache handshake decode; everything is forced low while in reset.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        d_wr_ack     = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (d_wr_req) begin
                        mem_enable  = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = d_wr_addr;
                        mem_data_in = d_wr_data;
                        d_wr_ack    = 1'b1;
                    end else if (d_fill_req) begin
                        base_d      = d_fill_addr & BASE_MASK;
                        issue_cnt_d = '0;
                        ret_cnt_d   = '0;
                        state_d     = D_FILL;
                    end else if (i_fill_req) begin
                        base_d      = i_fill_addr & BASE_MASK;
                        issue_cnt_d = '0;
                        ret_cnt_d   = '0;
                        state_d     = I_FILL;
                    end
                end

                I_FILL, D_FILL: begin
                    i_grant = (state_q == I_FILL);
                    d_grant = (state_q == D_FILL);

                    if (issue_cnt_q < CNT_W'(CHUNKS)) begin
                        mem_enable  = 1'b1;
                        mem_addr    = base_q + (ADDR_W'(issue_cnt_q) << 1);
                        issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    end

                    if (mem_data_valid) begin
                        i_data_valid = (state_q == I_FILL);
                        d_data_valid = (state_q == D_FILL);
                        ret_cnt_d    = ret_cnt_q + CNT_W'(1);
                        if (ret_cnt_q == CNT_W'(CHUNKS - 1)) begin
                            state_d = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    assign fill_data = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, fill priority, store handling, reset abort and stray returns.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_fill_req;
    logic [15:0] i_fill_addr;
    logic        d_fill_req;
    logic [15:0] d_fill_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic        i_grant;
    logic        d_grant;
    logic        i_data_valid;
    logic        d_data_valid;
    logic        d_wr_ack;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.CHUNKS(8), .OFFSET_BITS(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_fill_req     (i_fill_req),
        .i_fill_addr    (i_fill_addr),
        .d_fill_req     (d_fill_req),
        .d_fill_addr    (d_fill_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data_out   (mem_data_out),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .fill_data      (fill_data),
        .i_grant        (i_grant),
        .d_grant        (d_grant),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .d_wr_ack       (d_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; return pulses default low each cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_data_valid = 1'b0;
    endtask

    // One granted fill: reads at base+2k for k<8, a return every cycle from k=lat on.
    task automatic fill_run(input bit is_d, input logic [15:0] base, input int lat,
                            input int last_k, input bit wr_mid);
        for (int k = 0; k <= last_k; k++) begin
            tick();
            if (wr_mid && k == 2) begin
                d_wr_req  = 1'b1;
                d_wr_addr = 16'h3004;
                d_wr_data = 16'h1234;
            end
            if (k >= lat) begin
                mem_data_valid = 1'b1;
                mem_data_out   = 16'hC000 + 16'(k);
            end
            #1;
            chk("grant_owner", is_d ? d_grant : i_grant, 16'd1);
            chk("grant_other", is_d ? i_grant : d_grant, 16'd0);
            if (k < 8) begin
                chk("rd_enable", mem_enable, 16'd1);
                chk("rd_addr", mem_addr, base + 16'(2 * k));
            end else begin
                chk("rd_done_enable", mem_enable, 16'd0);
            end
            chk("rd_mem_wr", mem_wr, 16'd0);
            chk("fill_wr_ack", d_wr_ack, 16'd0);
            chk("dv_owner", is_d ? d_data_valid : i_data_valid, (k >= lat) ? 16'd1 : 16'd0);
            chk("dv_other", is_d ? i_data_valid : d_data_valid, 16'd0);
            if (k >= lat) chk("fill_data", fill_data, 16'hC000 + 16'(k));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        i_fill_req     = 1'b0;
        i_fill_addr    = 16'h0000;
        d_fill_req     = 1'b0;
        d_fill_addr    = 16'h0000;
        d_wr_req       = 1'b1;
        d_wr_addr      = 16'hFFFF;
        d_wr_data      = 16'hFFFF;
        mem_data_valid = 1'b1;
        mem_data_out   = 16'h5A5A;

        // Reset state: outputs low even with a store and a return present; fill_data passes through.
        #7;
        chk("rst_mem_enable", mem_enable, 16'd0);
        chk("rst_mem_wr", mem_wr, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_data_in", mem_data_in, 16'h0000);
        chk("rst_wr_ack", d_wr_ack, 16'd0);
        chk("rst_grants", {i_grant, d_grant}, 16'd0);
        chk("rst_dvs", {i_data_valid, d_data_valid}, 16'd0);
        chk("rst_fill_data", fill_data, 16'h5A5A);
        tick();
        rst_n    = 1'b1;
        d_wr_req = 1'b0;

        // I fill alone from 0x1236, memory latency 2; request held throughout.
        tick();
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h1236;
        #1;
        chk("i_grant_cycle_grant", i_grant, 16'd0);
        chk("i_grant_cycle_enable", mem_enable, 16'd0);
        fill_run(1'b0, 16'h1230, 2, 9, 1'b0);
        tick();
        i_fill_req = 1'b0;
        #1;
        chk("i_fill_exit_grant", i_grant, 16'd0);
        chk("i_fill_exit_enable", mem_enable, 16'd0);

        // Simultaneous fills: D wins, one IDLE cycle, then I.
        tick();
        d_fill_req  = 1'b1;
        d_fill_addr = 16'h4008;
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h0100;
        #1;
        chk("both_req_grants", {i_grant, d_grant}, 16'd0);
        fill_run(1'b1, 16'h4000, 1, 8, 1'b0);
        tick();
        d_fill_req = 1'b0;
        #1;
        chk("gap_grants", {i_grant, d_grant}, 16'd0);
        chk("gap_enable", mem_enable, 16'd0);
        fill_run(1'b0, 16'h0100, 3, 10, 1'b0);
        tick();
        i_fill_req = 1'b0;
        #1;
        chk("second_fill_exit", i_grant, 16'd0);

        // Store in IDLE together with a D fill request: store first, fill next cycle.
        tick();
        d_wr_req    = 1'b1;
        d_wr_addr   = 16'hA002;
        d_wr_data   = 16'hBEEF;
        d_fill_req  = 1'b1;
        d_fill_addr = 16'h5000;
        #1;
        chk("st_enable", mem_enable, 16'd1);
        chk("st_mem_wr", mem_wr, 16'd1);
        chk("st_addr", mem_addr, 16'hA002);
        chk("st_data", mem_data_in, 16'hBEEF);
        chk("st_ack", d_wr_ack, 16'd1);
        chk("st_d_grant", d_grant, 16'd0);
        tick();
        d_wr_req = 1'b0;
        #1;
        chk("post_st_ack", d_wr_ack, 16'd0);
        chk("post_st_enable", mem_enable, 16'd0);
        chk("post_st_d_grant", d_grant, 16'd0);
        fill_run(1'b1, 16'h5000, 1, 8, 1'b0);
        tick();
        d_fill_req = 1'b0;
        #1;
        chk("st_fill_exit", d_grant, 16'd0);

        // Store raised mid I fill: held off until the first IDLE cycle.
        tick();
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h2000;
        #1;
        chk("wrmid_grant_cycle", mem_enable, 16'd0);
        fill_run(1'b0, 16'h2000, 2, 9, 1'b1);
        tick();
        i_fill_req = 1'b0;
        #1;
        chk("late_st_grant", i_grant, 16'd0);
        chk("late_st_ack", d_wr_ack, 16'd1);
        chk("late_st_mem_wr", mem_wr, 16'd1);
        chk("late_st_enable", mem_enable, 16'd1);
        chk("late_st_addr", mem_addr, 16'h3004);
        chk("late_st_data", mem_data_in, 16'h1234);
        tick();
        d_wr_req = 1'b0;
        #1;
        chk("late_st_ack_drop", d_wr_ack, 16'd0);

        // Reset after the third return of an I fill; remaining returns are discarded.
        tick();
        i_fill_req  = 1'b1;
        i_fill_addr = 16'h1236;
        fill_run(1'b0, 16'h1230, 1, 3, 1'b0);
        tick();
        i_fill_req     = 1'b0;
        rst_n          = 1'b0;
        mem_data_valid = 1'b1;
        mem_data_out   = 16'h7777;
        #1;
        chk("abort_grant", i_grant, 16'd0);
        chk("abort_enable", mem_enable, 16'd0);
        chk("abort_addr", mem_addr, 16'h0000);
        chk("abort_dv", i_data_valid, 16'd0);
        chk("abort_fill_data", fill_data, 16'h7777);
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 0) rst_n = 1'b1;
            mem_data_valid = 1'b1;
            mem_data_out   = 16'h7000 + 16'(j);
            #1;
            chk("stray_dvs", {i_data_valid, d_data_valid}, 16'd0);
            chk("stray_grants", {i_grant, d_grant}, 16'd0);
            chk("stray_enable", mem_enable, 16'd0);
            chk("stray_fill_data", fill_data, 16'h7000 + 16'(j));
        end

        // Fill after stray returns must still take exactly 8 returns; top block of the space.
        tick();
        d_fill_req  = 1'b1;
        d_fill_addr = 16'hFFF8;
        #1;
        chk("top_grant_cycle", d_grant, 16'd0);
        fill_run(1'b1, 16'hFFF0, 2, 9, 1'b0);
        tick();
        d_fill_req = 1'b0;
        #1;
        chk("top_fill_exit", d_grant, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
